// File: rtl/gpu_mem_pkg.sv
// ---------------------------------------------------------------------------
// gpu_mem_pkg
// Shared types and constants for the GPU memory-fetch path.
//   arb_state_t : burst read arbiter state (IDLE / ISSUE / DATA)
//   REQ_VERTEX / REQ_COLOR : requester slot indices on the read arbiter
//   len_w()     : width of a burst-length field able to hold max_burst
// ---------------------------------------------------------------------------
package gpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DATA  = 2'd2
    } arb_state_t;

    localparam int REQ_VERTEX = 0;
    localparam int REQ_COLOR  = 1;

    // One extra bit so that max_burst itself is representable.
    function automatic int len_w(input int max_burst);
        return $clog2(max_burst) + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first asserted request at or after
// the pointer, wrapping around to index 0.
// Ports:
//   req_i       : request vector
//   ptr_i       : index with highest priority this cycle
//   grant_o     : one-hot grant (all zero when no request)
//   grant_idx_o : encoded index of the grant (0 when no request)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int N_REQ = 2,
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] grant_idx_o
);

    logic [N_REQ-1:0] mask;
    logic [N_REQ-1:0] req_hi;
    logic [N_REQ-1:0] pick;

    // Requests at or above the pointer win over the wrapped-around ones.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_mask
            assign mask[gi] = (IDX_W'(gi) >= ptr_i);
        end
    endgenerate

    assign req_hi = req_i & mask;
    assign pick   = (|req_hi) ? req_hi : req_i;

    // Scan from the top down so the lowest set bit of pick is kept.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (pick[k]) begin
                grant_o     = '0;
                grant_o[k]  = 1'b1;
                grant_idx_o = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// ---------------------------------------------------------------------------
// mem_read_arbiter
// Shares one Avalon-MM burst read port between N_REQ fetch units. One burst
// is outstanding at a time; grants rotate round-robin and returned beats are
// registered and steered to the owner of the active burst.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   req_valid/addr/len  : per-requester burst requests
//   req_ready           : one-hot accept, combinational in the IDLE cycle
//   rsp_valid/data/last : returned beat (one-hot owner), one cycle latency
//   mem_*               : Avalon-MM read master
//   busy                : arbiter not idle
// Optional build macro MEM_ARB_STATS_EN adds:
//   grant_count         : per-requester accepted-burst counters
//   stall_cycles        : ISSUE cycles spent under mem_waitrequest
// ---------------------------------------------------------------------------
module mem_read_arbiter
    import gpu_mem_pkg::*;
#(
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 16,
    parameter  int N_REQ      = 2,
    parameter  int MAX_BURST  = 8,
    localparam int LEN_W      = len_w(MAX_BURST),
    localparam int IDX_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [N_REQ-1:0]                  req_valid,
    input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]  req_addr,
    input  logic [N_REQ-1:0][LEN_W-1:0]       req_len,
    output logic [N_REQ-1:0]                  req_ready,
    output logic [N_REQ-1:0]                  rsp_valid,
    output logic [DATA_WIDTH-1:0]             rsp_data,
    output logic                              rsp_last,
    output logic                              mem_read,
    output logic [ADDR_WIDTH-1:0]             mem_address,
    output logic [LEN_W-1:0]                  mem_burstcount,
    input  logic                              mem_waitrequest,
    input  logic [DATA_WIDTH-1:0]             mem_readdata,
    input  logic                              mem_readdatavalid,
    output logic                              busy
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [N_REQ-1:0][31:0]            grant_count,
    output logic [31:0]                       stall_cycles
`endif
);

    arb_state_t              state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, owner_q, win_idx, ptr_next;
    logic [N_REQ-1:0]        win_grant, owner_onehot, rsp_valid_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LEN_W-1:0]        len_q, cnt_q, raw_len, eff_len;
    logic [DATA_WIDTH-1:0]   rsp_data_q;
    logic                    rsp_last_q;
    logic                    grant_fire, cmd_accept, beat_fire, last_beat;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req_i       (req_valid),
        .ptr_i       (ptr_q),
        .grant_o     (win_grant),
        .grant_idx_o (win_idx)
    );

    assign grant_fire = (state_q == IDLE) && (|req_valid);
    assign cmd_accept = (state_q == ISSUE) && !mem_waitrequest;
    assign beat_fire  = (state_q == DATA) && mem_readdatavalid;
    assign last_beat  = (cnt_q == len_q - LEN_W'(1));
    assign ptr_next   = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + IDX_W'(1);

    // A zero length still moves one beat; oversize bursts are clamped.
    always_comb begin
        raw_len = req_len[win_idx];
        if (raw_len == '0) begin
            eff_len = LEN_W'(1);
        end else if (raw_len > LEN_W'(MAX_BURST)) begin
            eff_len = LEN_W'(MAX_BURST);
        end else begin
            eff_len = raw_len;
        end
    end

    always_comb begin
        owner_onehot          = '0;
        owner_onehot[owner_q] = 1'b1;
    end

    // ---- FSM: state register ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- FSM: next state ----
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req_valid)             state_d = ISSUE;
            ISSUE:   if (cmd_accept)             state_d = DATA;
            DATA:    if (beat_fire && last_beat) state_d = IDLE;
            default:                             state_d = IDLE;
        endcase
    end

    // ---- FSM: outputs ----
    // Command fields are driven only while issuing so the bus idles at zero.
    always_comb begin
        req_ready      = '0;
        mem_read       = 1'b0;
        mem_address    = '0;
        mem_burstcount = '0;
        busy           = (state_q != IDLE);
        case (state_q)
            IDLE:  req_ready = win_grant;
            ISSUE: begin
                mem_read       = 1'b1;
                mem_address    = addr_q;
                mem_burstcount = len_q;
            end
            default: ;
        endcase
    end

    // ---- Burst context and response register ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q       <= '0;
            owner_q     <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= '0;
            rsp_last_q  <= 1'b0;
        end else begin
            rsp_valid_q <= '0;
            rsp_last_q  <= 1'b0;
            if (grant_fire) begin
                addr_q  <= req_addr[win_idx];
                len_q   <= eff_len;
                owner_q <= win_idx;
                ptr_q   <= ptr_next;
                cnt_q   <= '0;
            end
            if (beat_fire) begin
                rsp_data_q  <= mem_readdata;
                rsp_valid_q <= owner_onehot;
                rsp_last_q  <= last_beat;
                cnt_q       <= cnt_q + LEN_W'(1);
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_last  = rsp_last_q;

`ifdef MEM_ARB_STATS_EN
    logic [31:0] grant_cnt_q [N_REQ];
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N_REQ; k++) begin
                grant_cnt_q[k] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                if (grant_fire && (win_idx == IDX_W'(k))) begin
                    grant_cnt_q[k] <= grant_cnt_q[k] + 32'd1;
                end
            end
            if ((state_q == ISSUE) && mem_waitrequest) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_grant_cnt
            assign grant_count[gi] = grant_cnt_q[gi];
        end
    endgenerate

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_read_arbiter
// Scoreboarded bench: grants and commands are predicted from the request
// vector with an independent round-robin model; every beat driven on the
// memory side pushes its expected response, popped when rsp_valid appears.
// ---------------------------------------------------------------------------
module tb_mem_read_arbiter;
    import gpu_mem_pkg::*;

    localparam int AW = 32;
    localparam int DW = 16;
    localparam int NR = 2;
    localparam int MB = 8;
    localparam int LW = 4;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic [NR-1:0]          req_valid;
    logic [NR-1:0][AW-1:0]  req_addr;
    logic [NR-1:0][LW-1:0]  req_len;
    logic [NR-1:0]          req_ready;
    logic [NR-1:0]          rsp_valid;
    logic [DW-1:0]          rsp_data;
    logic                   rsp_last;
    logic                   mem_read;
    logic [AW-1:0]          mem_address;
    logic [LW-1:0]          mem_burstcount;
    logic                   mem_waitrequest;
    logic [DW-1:0]          mem_readdata;
    logic                   mem_readdatavalid;
    logic                   busy;
`ifdef MEM_ARB_STATS_EN
    logic [NR-1:0][31:0]    grant_count;
    logic [31:0]            stall_cycles;
`endif

    typedef struct {
        int          owner;
        logic [AW-1:0] addr;
        int          len;
    } cmd_t;

    typedef struct {
        logic [NR-1:0] vld;
        logic [DW-1:0] data;
        logic          last;
        int            cyc;
    } rsp_t;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    int   grant_hist[$];
    int   exp_order[4] = '{0, 1, 0, 1};

    int assert_cnt = 0;
    int fail_cnt   = 0;
    int cyc        = 0;
    int grant_cyc  = 0;
    int ptr_m      = 0;

    logic [NR-1:0] gm_exp;
    int            gm_w;
    rsp_t          rm_e;

    mem_read_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .N_REQ      (NR),
        .MAX_BURST  (MB)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .req_valid         (req_valid),
        .req_addr          (req_addr),
        .req_len           (req_len),
        .req_ready         (req_ready),
        .rsp_valid         (rsp_valid),
        .rsp_data          (rsp_data),
        .rsp_last          (rsp_last),
        .mem_read          (mem_read),
        .mem_address       (mem_address),
        .mem_burstcount    (mem_burstcount),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdata      (mem_readdata),
        .mem_readdatavalid (mem_readdatavalid),
        .busy              (busy)
`ifdef MEM_ARB_STATS_EN
        ,
        .grant_count       (grant_count),
        .stall_cycles      (stall_cycles)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        assert_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int eff_len(input int l);
        if (l == 0) return 1;
        if (l > MB) return MB;
        return l;
    endfunction

    function automatic int rr_pick(input logic [NR-1:0] v, input int p);
        for (int k = 0; k < NR; k++) begin
            if (v[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] onehot(input int i);
        logic [NR-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Grant monitor: predicts req_ready and records the expected command.
    always @(negedge clk) begin
        if (reset_n && (req_valid != '0 || req_ready != '0)) begin
            gm_exp = '0;
            gm_w   = -1;
            if (!busy && req_valid != '0) begin
                gm_w         = rr_pick(req_valid, ptr_m);
                gm_exp[gm_w] = 1'b1;
            end
            check_eq("req_ready", req_ready, gm_exp);
            if (gm_w >= 0) begin
                cmd_q.push_back('{gm_w, req_addr[gm_w], eff_len(int'(req_len[gm_w]))});
                ptr_m     = (gm_w + 1) % NR;
                grant_cyc = cyc;
            end
            for (int k = 0; k < NR; k++) begin
                if (req_ready[k]) grant_hist.push_back(k);
            end
        end
    end

    // Response monitor: pops the scoreboard on every returned beat.
    always @(negedge clk) begin
        if (reset_n) begin
            if (rsp_valid != '0) begin
                if (rsp_q.size() == 0) begin
                    check_eq("rsp_unexpected", rsp_valid, '0);
                end else begin
                    rm_e = rsp_q.pop_front();
                    check_eq("rsp_valid", rsp_valid, rm_e.vld);
                    check_eq("rsp_data", rsp_data, rm_e.data);
                    check_eq("rsp_last", rsp_last, rm_e.last);
                    check_eq("rsp_latency", cyc, rm_e.cyc);
                    if (rsp_last) check_eq("busy_after_last", busy, 1'b0);
                end
            end else if (rsp_last) begin
                check_eq("rsp_last_orphan", rsp_last, 1'b0);
            end
        end
    end

    task automatic raise_req(input int idx, input logic [AW-1:0] a, input int l);
        req_valid[idx] = 1'b1;
        req_addr[idx]  = a;
        req_len[idx]   = LW'(l);
    endtask

    task automatic check_quiet_outputs(input string tag);
        check_eq({tag, "_req_ready"}, req_ready, '0);
        check_eq({tag, "_rsp_valid"}, rsp_valid, '0);
        check_eq({tag, "_rsp_data"}, rsp_data, '0);
        check_eq({tag, "_rsp_last"}, rsp_last, 1'b0);
        check_eq({tag, "_mem_read"}, mem_read, 1'b0);
        check_eq({tag, "_mem_address"}, mem_address, '0);
        check_eq({tag, "_mem_burstcount"}, mem_burstcount, '0);
        check_eq({tag, "_busy"}, busy, 1'b0);
    endtask

    // Serves one burst as the memory slave: optional waitrequest stall,
    // then n_send beats (all beats when n_send < 0) with gap idle cycles.
    task automatic serve_burst(input int n_wait, input logic [DW-1:0] base, input int gap,
                               input logic [NR-1:0] drop_mask, input int n_send);
        cmd_t c;
        int   t;
        int   n;
`ifdef MEM_ARB_STATS_EN
        logic [31:0] stall_before;
        stall_before = stall_cycles;
`endif
        mem_waitrequest = (n_wait > 0);
        t = 0;
        while (!mem_read && t < 40) begin
            @(negedge clk);
            t++;
        end
        check_eq("cmd_seen", mem_read, 1'b1);
        req_valid = req_valid & ~drop_mask;
        if (cmd_q.size() == 0) begin
            check_eq("cmd_pending", cmd_q.size(), 1);
            mem_waitrequest = 1'b0;
            return;
        end
        c = cmd_q.pop_front();
        $display("burst: owner=%0d addr=0x%0h len=%0d wait=%0d", c.owner, c.addr, c.len, n_wait);
        check_eq("cmd_latency", cyc, grant_cyc + 1);
        for (int s = 0; s <= n_wait; s++) begin
            check_eq("mem_read", mem_read, 1'b1);
            check_eq("mem_address", mem_address, c.addr);
            check_eq("mem_burstcount", mem_burstcount, c.len);
            if (s < n_wait) begin
                @(posedge clk);
                #1;
                mem_waitrequest = (s + 1 < n_wait);
                @(negedge clk);
            end
        end
        @(posedge clk);
        #1;
        check_eq("mem_read_drop", mem_read, 1'b0);
`ifdef MEM_ARB_STATS_EN
        check_eq("stall_cycles", stall_cycles - stall_before, n_wait);
`endif
        n = (n_send < 0) ? c.len : n_send;
        for (int i = 0; i < n; i++) begin
            mem_readdatavalid = 1'b1;
            mem_readdata      = base + DW'(i);
            rsp_q.push_back('{onehot(c.owner), base + DW'(i), (i == c.len - 1), cyc + 1});
            @(posedge clk);
            #1;
            mem_readdatavalid = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        if (n == c.len) begin
            t = 0;
            while (rsp_q.size() != 0 && t < 12) begin
                @(negedge clk);
                t++;
            end
            check_eq("rsp_drain", rsp_q.size(), 0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n           = 1'b0;
        req_valid         = '0;
        req_addr          = '0;
        req_len           = '0;
        mem_waitrequest   = 1'b0;
        mem_readdata      = '0;
        mem_readdatavalid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_quiet_outputs("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Single vertex-fetch burst, beats 0xA1..0xA3.
        raise_req(REQ_VERTEX, 32'h1000, 3);
        serve_burst(0, 16'h00A1, 0, 2'b01, -1);

        // Color fetch stalled by waitrequest for 4 cycles, gapped beats.
        @(posedge clk);
        #1;
        raise_req(REQ_COLOR, 32'h4000, 4);
        serve_burst(4, 16'h00B0, 1, 2'b10, -1);

        // Both requesters held high: grants must rotate 0,1,0,1.
        @(posedge clk);
        #1;
        grant_hist.delete();
        raise_req(REQ_VERTEX, 32'h2000, 2);
        raise_req(REQ_COLOR, 32'h3000, 2);
        for (int k = 0; k < 4; k++) begin
            serve_burst(0, DW'(16'h0100 * (k + 1)), 0, (k == 3) ? 2'b11 : 2'b00, -1);
        end
        check_eq("grant_hist_len", grant_hist.size(), 4);
        for (int k = 0; k < 4 && k < grant_hist.size(); k++) begin
            check_eq("grant_order", grant_hist[k], exp_order[k]);
        end

        // Length edges: 0 becomes 1, 12 is clamped to 8.
        @(posedge clk);
        #1;
        raise_req(REQ_VERTEX, 32'h5000, 0);
        serve_burst(0, 16'h00C0, 0, 2'b01, -1);
        @(posedge clk);
        #1;
        raise_req(REQ_COLOR, 32'h6000, 12);
        serve_burst(0, 16'h00D0, 0, 2'b10, -1);

        // Stray read data while idle must be ignored.
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            mem_readdatavalid = 1'b1;
            mem_readdata      = 16'hDEAD;
            @(negedge clk);
            check_eq("stray_busy", busy, 1'b0);
            check_eq("stray_rsp_valid", rsp_valid, '0);
            @(posedge clk);
            #1;
        end
        mem_readdatavalid = 1'b0;
        @(negedge clk);
        check_eq("stray_rsp_valid_end", rsp_valid, '0);
        check_eq("stray_busy_end", busy, 1'b0);

        // Reset after 2 of 5 beats, then a fresh pair of requests.
        @(posedge clk);
        #1;
        raise_req(REQ_VERTEX, 32'h7000, 5);
        serve_burst(0, 16'h00E0, 0, 2'b01, 2);
        reset_n = 1'b0;
        rsp_q.delete();
        cmd_q.delete();
        ptr_m = 0;
        @(negedge clk);
        check_quiet_outputs("midreset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        raise_req(REQ_VERTEX, 32'h8000, 5);
        raise_req(REQ_COLOR, 32'h9000, 5);
        serve_burst(0, 16'h00F0, 0, 2'b01, -1);
        serve_burst(0, 16'h0070, 0, 2'b10, -1);

        repeat (3) @(posedge clk);
        #1;
        check_eq("final_busy", busy, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
